// File: rtl/output_port_pkg.sv
// ============================================================================
// Module : output_port_pkg
// Brief  : Shared NIC definitions for the transmit port: link geometry, flit
//          type codes, flit field positions, FSM state encoding and clog2.
//          Geometry macros (FLIT_WIDTH, MAX_PACKET_LENGHT, N_OF_VC, N_OF_VN)
//          may be supplied on the command line; defaults are provided here.
// Rev    : 1.0 - initial release
// ============================================================================
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 8
`endif
`ifndef N_OF_VC
`define N_OF_VC 2
`endif
`ifndef N_OF_VN
`define N_OF_VN 2
`endif

`default_nettype none

package output_port_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int FLIT_WIDTH        = `FLIT_WIDTH;
  localparam int MAX_PACKET_LENGHT = `MAX_PACKET_LENGHT;
  localparam int N_OF_VC           = `N_OF_VC;
  localparam int N_OF_VN           = `N_OF_VN;
  localparam int N_TOT_OF_VC       = N_OF_VC * N_OF_VN;

  localparam int N_BITS_POINTER_FLITS_BUFFER =
      (MAX_PACKET_LENGHT > 1) ? clog2(MAX_PACKET_LENGHT) : 1;
  localparam int N_BITS_POINTER  = (N_TOT_OF_VC > 1) ? clog2(N_TOT_OF_VC) : 1;
  localparam int N_BITS_VC_IN_VN = (N_OF_VC > 1) ? clog2(N_OF_VC) : 1;
  localparam int N_BITS_VN       = (N_OF_VN > 1) ? clog2(N_OF_VN) : 1;

  // Flit field layout: type in [1:0], global VC index right above it.
  localparam int TYPE_LSB   = 0;
  localparam int TYPE_WIDTH = 2;
  localparam int VC_LSB     = 2;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  function automatic logic is_packet_end(input logic [TYPE_WIDTH-1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/output_port_vc_alloc.sv
// ============================================================================
// Module : output_port_vc_alloc
// Brief  : Downstream VC allocator for one virtual network at a time.
//          A VC is eligible when it is free downstream and its credit counter
//          is full. Selection is fixed priority (lowest VC) by default, or
//          per-VN round robin when OUTPUT_PORT_RR_ALLOC_EN is defined.
// Ports  : clk, rst       clock, synchronous active-high reset
//          i_vn           virtual network being allocated
//          i_free         per-VC downstream free level
//          i_cred_full    per-VC "credit counter is full"
//          i_update       allocation accepted (advances RR pointer)
//          o_grant        an eligible VC exists
//          o_vc           global index of the chosen VC (vc*N_OF_VN+vn)
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_port_vc_alloc
  import output_port_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_BITS_VN-1:0]       i_vn,
  input  logic [N_TOT_OF_VC-1:0]     i_free,
  input  logic [N_TOT_OF_VC-1:0]     i_cred_full,
  input  logic                       i_update,
  output logic                       o_grant,
  output logic [N_BITS_POINTER-1:0]  o_vc
);

  logic [N_OF_VC-1:0]          w_eligible;
  logic [N_BITS_VC_IN_VN-1:0]  w_start;
  logic [N_BITS_VC_IN_VN-1:0]  w_sel;
  logic                        w_found;

  // Eligibility of the VCs belonging to the requested VN, indexed by local vc.
  always_comb begin
    w_eligible = '0;
    for (int j = 0; j < N_OF_VC; j++) begin
      w_eligible[j] = i_free[j*N_OF_VN + int'(i_vn)] &&
                      i_cred_full[j*N_OF_VN + int'(i_vn)];
    end
  end

  // First eligible VC scanning upward from w_start (wrapping).
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < N_OF_VC; k++) begin
      if (!w_found && w_eligible[(int'(w_start) + k) % N_OF_VC]) begin
        w_found = 1'b1;
        w_sel   = N_BITS_VC_IN_VN'((int'(w_start) + k) % N_OF_VC);
      end
    end
  end

  assign o_grant = w_found;
  assign o_vc    = N_BITS_POINTER'(int'(w_sel) * N_OF_VN + int'(i_vn));

`ifdef OUTPUT_PORT_RR_ALLOC_EN
  // Pointer holds the local VC where the next search begins, i.e. one past
  // the last VC granted in that VN.
  logic [N_BITS_VC_IN_VN-1:0] r_rr_ptr [N_OF_VN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_OF_VN; n++) begin
        r_rr_ptr[n] <= '0;
      end
    end else if (i_update) begin
      r_rr_ptr[i_vn] <= N_BITS_VC_IN_VN'((int'(w_sel) + 1) % N_OF_VC);
    end
  end

  assign w_start = r_rr_ptr[i_vn];
`else
  logic w_unused;
  assign w_unused = clk ^ rst ^ i_update;
  assign w_start  = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/output_port.sv
// ============================================================================
// Module : output_port
// Brief  : NIC transmit port. Accepts a whole packet from the message queue,
//          allocates a downstream VC inside the packet's VN, rewrites the VC
//          field of every flit and serialises one flit per cycle under
//          per-VC credit flow control.
//          Optional macro OUTPUT_PORT_RR_ALLOC_EN selects round-robin VC
//          allocation per VN (default: fixed priority, lowest VC).
// Ports  : clk, rst          clock, synchronous active-high reset
//          r_msg_to_pkt_i    packet hand-over request
//          g_msg_to_pkt_o    hand-over grant (port idle)
//          in_link_i         packet, flit k at [k*FLIT_WIDTH +: FLIT_WIDTH]
//          out_link_o        flit toward the router
//          is_valid_o        out_link_o valid this cycle
//          credit_signal_i   per-VC one-slot-freed pulses
//          free_signal_i     per-VC downstream unallocated level
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_port
  import output_port_pkg::*;
#(
  parameter int N_CREDITS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    r_msg_to_pkt_i,
  output logic                                    g_msg_to_pkt_o,
  input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
  output logic [FLIT_WIDTH-1:0]                   out_link_o,
  output logic                                    is_valid_o,
  input  logic [N_TOT_OF_VC-1:0]                  credit_signal_i,
  input  logic [N_TOT_OF_VC-1:0]                  free_signal_i
);

  localparam int                   CREDIT_W     = clog2(N_CREDITS + 1);
  localparam logic [CREDIT_W-1:0]  CREDITS_FULL = CREDIT_W'(N_CREDITS);
  localparam int                   NBF          = N_BITS_POINTER_FLITS_BUFFER;

  state_e                                  r_state;
  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] r_pkt;
  logic [N_BITS_POINTER-1:0]               r_vc;
  logic [NBF-1:0]                          r_ptr;
  logic [CREDIT_W-1:0]                     r_credits [N_TOT_OF_VC];

  logic [NBF-1:0]                w_last_idx;
  logic [N_BITS_POINTER-1:0]     w_head_vc;
  logic [N_BITS_VN-1:0]          w_vn;
  logic [N_TOT_OF_VC-1:0]        w_cred_full;
  logic [N_TOT_OF_VC-1:0]        w_dec;
  logic                          w_grant;
  logic [N_BITS_POINTER-1:0]     w_grant_vc;
  logic                          w_alloc_fire;
  logic                          w_send;
  logic [FLIT_WIDTH-1:0]         w_flit;

  assign g_msg_to_pkt_o = (r_state == ST_IDLE);

  // Packet length: the lowest slot carrying a tail/head-tail type ends it;
  // with no terminator every slot is sent.
  always_comb begin
    w_last_idx = NBF'(MAX_PACKET_LENGHT - 1);
    for (int k = MAX_PACKET_LENGHT - 1; k >= 0; k--) begin
      if (is_packet_end(r_pkt[k*FLIT_WIDTH + TYPE_LSB +: TYPE_WIDTH])) begin
        w_last_idx = NBF'(k);
      end
    end
  end

  // VN lives in the low part of the head's VC field.
  assign w_head_vc = r_pkt[VC_LSB +: N_BITS_POINTER];
  assign w_vn      = N_BITS_VN'(int'(w_head_vc) % N_OF_VN);

  always_comb begin
    w_cred_full = '0;
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      w_cred_full[v] = (r_credits[v] == CREDITS_FULL);
    end
  end

  output_port_vc_alloc u_vc_alloc (
    .clk         (clk),
    .rst         (rst),
    .i_vn        (w_vn),
    .i_free      (free_signal_i),
    .i_cred_full (w_cred_full),
    .i_update    (w_alloc_fire),
    .o_grant     (w_grant),
    .o_vc        (w_grant_vc)
  );

  assign w_alloc_fire = (r_state == ST_ALLOC) && w_grant;
  assign w_send       = (r_state == ST_SEND) && (r_credits[r_vc] != '0);

  // Current flit with its VC field replaced by the allocated VC.
  always_comb begin
    w_flit = r_pkt[int'(r_ptr)*FLIT_WIDTH +: FLIT_WIDTH];
    w_flit[VC_LSB +: N_BITS_POINTER] = r_vc;
  end

  always_comb begin
    w_dec = '0;
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      w_dec[v] = w_send && (r_vc == N_BITS_POINTER'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pkt      <= '0;
      r_vc       <= '0;
      r_ptr      <= '0;
      out_link_o <= '0;
      is_valid_o <= 1'b0;
    end else begin
      is_valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_msg_to_pkt_i) begin
            r_pkt   <= in_link_i;
            r_state <= ST_ALLOC;
          end
        end
        ST_ALLOC: begin
          if (w_grant) begin
            r_vc    <= w_grant_vc;
            r_ptr   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_send) begin
            out_link_o <= w_flit;
            is_valid_o <= 1'b1;
            if (r_ptr == w_last_idx) begin
              r_state <= ST_IDLE;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A send and a return on the same VC in one cycle cancel out; returns
  // beyond the downstream depth are ignored.
  always_ff @(posedge clk) begin
    for (int v = 0; v < N_TOT_OF_VC; v++) begin
      if (rst) begin
        r_credits[v] <= CREDITS_FULL;
      end else if (w_dec[v] && !credit_signal_i[v]) begin
        r_credits[v] <= r_credits[v] - 1'b1;
      end else if (!w_dec[v] && credit_signal_i[v] && (r_credits[v] != CREDITS_FULL)) begin
        r_credits[v] <= r_credits[v] + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
